// File: rtl/dbg_apb_pkg.sv
// Shared types and helpers for the debug APB crossbar: FSM state encoding,
// one-hot select decoding and the default error read-data pattern.
package dbg_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dbg_apb_state_e;

    localparam logic [31:0] DBG_APB_ERR_RDATA = 32'hDEAD_BEEF;

    // True when exactly one bit of the (zero-extended) select vector is set.
    function automatic logic onehot_valid(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    // Index of the lowest set bit; only meaningful when onehot_valid(v) holds.
    function automatic logic [4:0] onehot2idx(input logic [31:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dbg_apb_watchdog.sv
// Access-phase cycle counter for the debug APB crossbar; flags expiry on the
// last permitted cycle. TIMEOUT_CYCLES = 0 disables expiry entirely.
module dbg_apb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);
    localparam logic [CW-1:0] MAX = {CW{1'b1}};
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturates rather than wrapping so a stuck slave cannot re-arm the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = ENABLED && en_i && (cnt_q == LAST);

endmodule

// File: rtl/dbg_apb_xbar.sv
// Debug APB crossbar: routes select/enable to one of NR_SLAVES slaves and
// returns a registered response with timeout, select-error and sticky faults.
module dbg_apb_xbar
    import dbg_apb_pkg::*;
#(
    parameter int                     NR_SLAVES      = 4,
    parameter int                     RDATA_WIDTH    = 32,
    parameter int                     TIMEOUT_CYCLES = 64,
    parameter logic [RDATA_WIDTH-1:0] ERR_RDATA      = RDATA_WIDTH'(DBG_APB_ERR_RDATA)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NR_SLAVES-1:0]   sel,
    input  logic                   enable,
    output logic                   ready,
    output logic [RDATA_WIDTH-1:0] rdata,
    output logic                   slverr,
    output logic [NR_SLAVES-1:0]   s_sel,
    output logic                   s_enable,
    input  logic [NR_SLAVES-1:0]   s2m_ready,
    input  logic [RDATA_WIDTH-1:0] s2m_rdata [NR_SLAVES],
    output logic [NR_SLAVES-1:0]   fault_sticky,
    output logic                   sel_err_sticky,
    input  logic                   clr_sticky
);

    localparam int IW = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;

    dbg_apb_state_e         state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   ready_q, ready_d;
    logic                   slverr_q, slverr_d;
    logic [RDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NR_SLAVES-1:0]   fault_q, fault_d;
    logic                   sel_err_q, sel_err_d;

    logic [31:0]            sel_ext;
    logic                   sel_valid;
    logic [IW-1:0]          sel_idx;
    logic [NR_SLAVES-1:0]   idx_onehot;
    logic                   wd_en;
    logic                   wd_clr;
    logic                   wd_expire;
    logic                   timeout_hit;
    logic                   sel_err_set;
    logic [NR_SLAVES-1:0]   fault_set;

    assign sel_ext    = 32'(sel);
    assign sel_valid  = onehot_valid(sel_ext);
    assign sel_idx    = IW'(onehot2idx(sel_ext));
    assign idx_onehot = NR_SLAVES'(1) << idx_q;

    assign wd_en  = (state_q == ACCESS);
    assign wd_clr = (state_q != ACCESS);

    dbg_apb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (wd_en),
        .clr_i    (wd_clr),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        slverr_d    = 1'b0;
        timeout_hit = 1'b0;
        sel_err_set = 1'b0;
        s_sel       = '0;
        s_enable    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    s_sel = sel;
                end
                if ((sel != '0) && !enable) begin
                    idx_d   = sel_idx;
                    valid_d = sel_valid;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                s_sel = valid_q ? idx_onehot : '0;
                if (sel == '0) begin
                    state_d = IDLE;
                end else if (enable) begin
                    if (valid_q) begin
                        state_d = ACCESS;
                    end else begin
                        state_d     = RESP;
                        ready_d     = 1'b1;
                        slverr_d    = 1'b1;
                        rdata_d     = ERR_RDATA;
                        sel_err_set = 1'b1;
                    end
                end
            end
            ACCESS: begin
                s_sel    = idx_onehot;
                s_enable = 1'b1;
                // A master that abandons the transfer gets no response at all.
                if (!enable || !sel[idx_q]) begin
                    state_d = IDLE;
                end else if (s2m_ready[idx_q]) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = s2m_rdata[idx_q];
                end else if (wd_expire) begin
                    state_d     = RESP;
                    ready_d     = 1'b1;
                    slverr_d    = 1'b1;
                    rdata_d     = ERR_RDATA;
                    timeout_hit = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NR_SLAVES; gi++) begin : g_fault_set
        assign fault_set[gi] = timeout_hit && (idx_q == IW'(gi));
    end

    // Clear first, then OR in new events so a same-cycle set survives the clear.
    always_comb begin
        fault_d   = (clr_sticky ? '0 : fault_q) | fault_set;
        sel_err_d = (clr_sticky ? 1'b0 : sel_err_q) | sel_err_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            slverr_q  <= 1'b0;
            rdata_q   <= '0;
            fault_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            slverr_q  <= slverr_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign ready          = ready_q;
    assign slverr         = slverr_q;
    assign rdata          = rdata_q;
    assign fault_sticky   = fault_q;
    assign sel_err_sticky = sel_err_q;

endmodule

// File: tb/tb_dbg_apb_xbar.sv
// Directed bench for dbg_apb_xbar (4 slaves, 8-cycle timeout).
module tb_dbg_apb_xbar;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sel;
    logic        enable;
    logic        ready;
    logic [31:0] rdata;
    logic        slverr;
    logic [3:0]  s_sel;
    logic        s_enable;
    logic [3:0]  s2m_ready;
    logic [31:0] s2m_rdata [4];
    logic [3:0]  fault_sticky;
    logic        sel_err_sticky;
    logic        clr_sticky;

    int pass_cnt;
    int total_cnt;

    dbg_apb_xbar #(
        .NR_SLAVES      (4),
        .RDATA_WIDTH    (32),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sel            (sel),
        .enable         (enable),
        .ready          (ready),
        .rdata          (rdata),
        .slverr         (slverr),
        .s_sel          (s_sel),
        .s_enable       (s_enable),
        .s2m_ready      (s2m_ready),
        .s2m_rdata      (s2m_rdata),
        .fault_sticky   (fault_sticky),
        .sel_err_sticky (sel_err_sticky),
        .clr_sticky     (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = '0; enable = 1'b0; s2m_ready = '0; clr_sticky = 1'b0;
        s2m_rdata[0] = 32'h1111_1111; s2m_rdata[1] = 32'h2222_2222;
        s2m_rdata[2] = 32'h3333_3333; s2m_rdata[3] = 32'h4444_4444;
        tick(); tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (slverr !== 1'b0) $display("FAIL rst_slverr: got %b want 0", slverr); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 00000000", rdata); else pass_cnt++;
        total_cnt++; if (s_sel !== 4'b0000) $display("FAIL rst_s_sel: got %b want 0000", s_sel); else pass_cnt++;
        total_cnt++; if (s_enable !== 1'b0) $display("FAIL rst_s_enable: got %b want 0", s_enable); else pass_cnt++;
        total_cnt++; if (fault_sticky !== 4'b0000) $display("FAIL rst_fault: got %b want 0000", fault_sticky); else pass_cnt++;
        total_cnt++; if (sel_err_sticky !== 1'b0) $display("FAIL rst_sel_err: got %b want 0", sel_err_sticky); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        $display("txn: reset released");
    endtask

    task automatic test_read();
        sel = 4'b0100; enable = 1'b0;
        #1;
        total_cnt++; if (s_sel !== 4'b0100) $display("FAIL rd_idle_s_sel: got %b want 0100", s_sel); else pass_cnt++;
        tick();
        total_cnt++; if (s_sel !== 4'b0100) $display("FAIL rd_setup_s_sel: got %b want 0100", s_sel); else pass_cnt++;
        total_cnt++; if (s_enable !== 1'b0) $display("FAIL rd_setup_s_enable: got %b want 0", s_enable); else pass_cnt++;
        enable = 1'b1;
        tick();
        total_cnt++; if (s_enable !== 1'b1) $display("FAIL rd_access_s_enable: got %b want 1", s_enable); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (ready !== 1'b0) $display("FAIL rd_wait_ready: got %b want 0 (cycle %0d)", ready, i); else pass_cnt++;
        end
        s2m_ready = 4'b0100; s2m_rdata[2] = 32'h1234_5678;
        tick();
        total_cnt++; if (ready !== 1'b1) $display("FAIL rd_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h1234_5678) $display("FAIL rd_rdata: got %h want 12345678", rdata); else pass_cnt++;
        total_cnt++; if (slverr !== 1'b0) $display("FAIL rd_slverr: got %b want 0", slverr); else pass_cnt++;
        total_cnt++; if (s_enable !== 1'b0) $display("FAIL rd_resp_s_enable: got %b want 0", s_enable); else pass_cnt++;
        total_cnt++; if (s_sel !== 4'b0000) $display("FAIL rd_resp_s_sel: got %b want 0000", s_sel); else pass_cnt++;
        s2m_ready = '0; sel = '0; enable = 1'b0;
        tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL rd_ready_pulse: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h1234_5678) $display("FAIL rd_rdata_hold: got %h want 12345678", rdata); else pass_cnt++;
        $display("txn: read slave 2 rdata=%h slverr=%b", rdata, slverr);
    endtask

    task automatic test_timeout();
        sel = 4'b0010; enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            total_cnt++; if (ready !== 1'b0) $display("FAIL to_early_ready: got %b want 0 (cycle %0d)", ready, i); else pass_cnt++;
        end
        tick();
        total_cnt++; if (ready !== 1'b1) $display("FAIL to_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (slverr !== 1'b1) $display("FAIL to_slverr: got %b want 1", slverr); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL to_rdata: got %h want deadbeef", rdata); else pass_cnt++;
        total_cnt++; if (fault_sticky !== 4'b0010) $display("FAIL to_fault: got %b want 0010", fault_sticky); else pass_cnt++;
        sel = '0; enable = 1'b0;
        tick();
        total_cnt++; if (slverr !== 1'b0) $display("FAIL to_slverr_clear: got %b want 0", slverr); else pass_cnt++;
        total_cnt++; if (fault_sticky !== 4'b0010) $display("FAIL to_fault_hold: got %b want 0010", fault_sticky); else pass_cnt++;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total_cnt++; if (fault_sticky !== 4'b0000) $display("FAIL to_fault_clr: got %b want 0000", fault_sticky); else pass_cnt++;
        $display("txn: timeout slave 1 faults cleared");
    endtask

    task automatic test_sel_err();
        sel = 4'b0101; enable = 1'b0;
        #1;
        total_cnt++; if (s_sel !== 4'b0000) $display("FAIL se_idle_s_sel: got %b want 0000", s_sel); else pass_cnt++;
        tick();
        total_cnt++; if (s_sel !== 4'b0000) $display("FAIL se_setup_s_sel: got %b want 0000", s_sel); else pass_cnt++;
        enable = 1'b1;
        tick();
        total_cnt++; if (ready !== 1'b1) $display("FAIL se_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (slverr !== 1'b1) $display("FAIL se_slverr: got %b want 1", slverr); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL se_rdata: got %h want deadbeef", rdata); else pass_cnt++;
        total_cnt++; if (sel_err_sticky !== 1'b1) $display("FAIL se_sticky: got %b want 1", sel_err_sticky); else pass_cnt++;
        total_cnt++; if (s_sel !== 4'b0000) $display("FAIL se_resp_s_sel: got %b want 0000", s_sel); else pass_cnt++;
        sel = '0; enable = 1'b0;
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        total_cnt++; if (sel_err_sticky !== 1'b0) $display("FAIL se_sticky_clr: got %b want 0", sel_err_sticky); else pass_cnt++;
        $display("txn: select error on sel=0101");
    endtask

    task automatic test_ready_vs_timeout();
        sel = 4'b1000; enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        s2m_ready = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            tick();
            total_cnt++; if (ready !== 1'b0) $display("FAIL rt_stray_ready: got %b want 0 (cycle %0d)", ready, i); else pass_cnt++;
        end
        s2m_ready = 4'b1000; s2m_rdata[3] = 32'hCAFE_F00D;
        tick();
        total_cnt++; if (ready !== 1'b1) $display("FAIL rt_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (slverr !== 1'b0) $display("FAIL rt_slverr: got %b want 0", slverr); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hCAFE_F00D) $display("FAIL rt_rdata: got %h want cafef00d", rdata); else pass_cnt++;
        total_cnt++; if (fault_sticky !== 4'b0000) $display("FAIL rt_fault: got %b want 0000", fault_sticky); else pass_cnt++;
        s2m_ready = '0; sel = '0; enable = 1'b0;
        tick();
        $display("txn: read slave 3 on timeout cycle rdata=%h", rdata);
    endtask

    task automatic test_reset_mid_access();
        sel = 4'b0001; enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
        rst_n = 1'b0; sel = '0; enable = 1'b0;
        tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL rm_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL rm_rdata: got %h want 00000000", rdata); else pass_cnt++;
        total_cnt++; if (s_enable !== 1'b0) $display("FAIL rm_s_enable: got %b want 0", s_enable); else pass_cnt++;
        total_cnt++; if (s_sel !== 4'b0000) $display("FAIL rm_s_sel: got %b want 0000", s_sel); else pass_cnt++;
        rst_n = 1'b1;
        sel = 4'b0001;
        tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL rm_no_pulse: got %b want 0", ready); else pass_cnt++;
        enable = 1'b1;
        tick();
        s2m_ready = 4'b0001; s2m_rdata[0] = 32'hA5A5_0001;
        total_cnt++; if (s_enable !== 1'b1) $display("FAIL rm_access: got %b want 1", s_enable); else pass_cnt++;
        tick();
        total_cnt++; if (ready !== 1'b1) $display("FAIL rm_fresh_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hA5A5_0001) $display("FAIL rm_fresh_rdata: got %h want a5a50001", rdata); else pass_cnt++;
        s2m_ready = '0; sel = '0; enable = 1'b0;
        tick();
        $display("txn: reset mid-access then read slave 0 rdata=%h", rdata);
    endtask

    task automatic test_abort_back_to_back();
        sel = 4'b0100; enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        tick();
        sel = '0; enable = 1'b0;
        tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL ab_ready: got %b want 0", ready); else pass_cnt++;
        total_cnt++; if (s_sel !== 4'b0000) $display("FAIL ab_s_sel: got %b want 0000", s_sel); else pass_cnt++;
        total_cnt++; if (s_enable !== 1'b0) $display("FAIL ab_s_enable: got %b want 0", s_enable); else pass_cnt++;
        sel = 4'b0010;
        tick();
        total_cnt++; if (ready !== 1'b0) $display("FAIL ab_still_no_ready: got %b want 0", ready); else pass_cnt++;
        enable = 1'b1;
        tick();
        s2m_ready = 4'b0010; s2m_rdata[1] = 32'h0BAD_F00D;
        tick();
        total_cnt++; if (ready !== 1'b1) $display("FAIL ab_b2b_ready: got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0BAD_F00D) $display("FAIL ab_b2b_rdata: got %h want 0badf00d", rdata); else pass_cnt++;
        total_cnt++; if (slverr !== 1'b0) $display("FAIL ab_b2b_slverr: got %b want 0", slverr); else pass_cnt++;
        s2m_ready = '0; sel = '0; enable = 1'b0;
        tick();
        $display("txn: abort slave 2 then read slave 1 rdata=%h", rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "tb_dbg_apb_xbar timeout");
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_read();
        test_timeout();
        test_sel_err();
        test_ready_vs_timeout();
        test_reset_mid_access();
        test_abort_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dbg_apb_xbar.md
Name: dbg_apb_xbar

Overview:
- Parametrised successor of the debug APB bus. Sits between the debug access port's APB master side and NR_SLAVES core debug APB slaves.
- Forwards select/enable to the addressed slave and muxes that slave's ready/rdata back to the master.
- Adds behaviour the old bus lacks: a registered response stage, slave-timeout watchdog, select-error detection, PSLVERR-style error signalling and per-slave sticky fault status.
- addr/wr_rd/wdata/wstrobe are broadcast to slaves outside this block.

Parameters:
- NR_SLAVES, 4, number of debug APB slaves (1..32)
- RDATA_WIDTH, 32, read data width
- TIMEOUT_CYCLES, 64, access-phase cycles before timeout; 0 disables the watchdog
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on any error response

Ports:
- clk  in  1  bus clock
- rst_n  in  1  synchronous active-low reset
- sel  in  NR_SLAVES  master slave-select, must be one-hot
- enable  in  1  master access phase
- ready  out  1  transfer complete to master, registered
- rdata  out  RDATA_WIDTH  read data to master, registered
- slverr  out  1  error response, valid with ready
- s_sel  out  NR_SLAVES  gated select to slaves
- s_enable  out  1  gated enable to slaves
- s2m_ready  in  NR_SLAVES  per-slave ready
- s2m_rdata  in  NR_SLAVES x RDATA_WIDTH  per-slave rdata (unpacked array)
- fault_sticky  out  NR_SLAVES  per-slave timeout flag
- sel_err_sticky  out  1  non-one-hot select seen
- clr_sticky  in  1  clears all sticky flags

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; ready=0, slverr=0, rdata=0, s_sel=0, s_enable=0, all sticky flags 0, counter 0. Reset mid-transfer aborts with no ready pulse.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: when sel!=0 and enable=0, latch slave index idx and a one-hot-valid flag, go to SETUP. s_sel=sel if valid, else 0.
- SETUP: s_sel=onehot(idx) when valid, s_enable=0.
  - enable=1 and valid -> ACCESS.
  - enable=1 and invalid -> RESP with slverr, and sel_err_sticky set.
  - sel==0 -> IDLE.
- ACCESS: s_sel=onehot(idx), s_enable=1, counter increments each cycle.
  - s2m_ready[idx]=1: capture s2m_rdata[idx], slverr=0, go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: capture ERR_RDATA, slverr=1, set fault_sticky[idx], go to RESP.
  - Ready wins over timeout when both occur in the same cycle.
  - Master drops sel[idx] or enable: abort to IDLE, no response, s_sel/s_enable drop next cycle.
- RESP: ready=1 for exactly one cycle with held rdata/slverr; s_sel=0, s_enable=0 so the slave cannot re-trigger. Next state IDLE; the counter clears.
- Outside RESP: ready=0, slverr=0, and rdata holds its last value.
- Latency: slave ready at cycle t -> master ready at t+1. Minimum transfer is SETUP + 1 ACCESS + RESP = 3 cycles.
- Slave readies of non-selected slaves are ignored.
- Widths:
  - idx width = max(1, clog2(NR_SLAVES)).
  - Counter width = clog2(TIMEOUT_CYCLES+1); it saturates and does not wrap.
- Sticky flags:
  - clr_sticky=1 clears all flags.
  - If a clear and a set occur in the same cycle, the set wins.
- All outputs are registered except s_sel and s_enable, which are decoded from state and idx.

Decomposition:
- Package dbg_apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - function onehot_valid()
  - function onehot2idx()
  - default ERR_RDATA constant
- Sub-module dbg_apb_watchdog: counter, enable/clear/expire, parametrised by TIMEOUT_CYCLES.

Test Plan:
1. NR_SLAVES=4, read slave 2, s2m_ready[2] after 3 wait cycles with rdata 32'h1234_5678 -> ready=1 one cycle later, rdata=32'h1234_5678, slverr=0, s_enable low during RESP.
2. TIMEOUT_CYCLES=8, select slave 1, never ready -> after 8 ACCESS cycles ready=1, slverr=1, rdata=32'hDEAD_BEEF, fault_sticky=4'b0010; then clr_sticky -> 4'b0000.
3. sel=4'b0101 then enable -> s_sel stays 0, ready+slverr in the cycle after enable, sel_err_sticky=1.
4. s2m_ready[1]=1 while slave 3 is selected, then s2m_ready[3]=1 on the timeout cycle -> stray ready ignored, ready wins over timeout, slverr=0, fault_sticky[3]=0.
5. rst_n=0 mid-ACCESS -> next cycle all outputs 0 and state IDLE; a fresh transfer completes normally.
6. Master drops enable mid-ACCESS -> no ready pulse, s_sel=0 the next cycle, and a back-to-back new transfer succeeds.
